// File: rtl/sr_bank_pkg.sv
// Shared opcode and FSM encodings for the SR bank command controller.
package sr_bank_pkg;

    typedef logic [1:0] op_t;
    typedef logic [1:0] state_t;

    localparam op_t OP_NOP = 2'b00;
    localparam op_t OP_SET = 2'b01;
    localparam op_t OP_CLR = 2'b10;
    localparam op_t OP_TGL = 2'b11;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_DRIVE = 2'd1;
    localparam state_t ST_CHECK = 2'd2;

endpackage

// File: rtl/sr_rr_arb.sv
// Round-robin arbiter: picks the first requester at or after the pointer.
// Latency: combinational winner, pointer updates on the edge after an advance strobe.
// Backpressure: none; the caller decides when a grant is taken via adv.
module sr_rr_arb #(
    parameter int NREQ = 4,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    input  logic            adv,
    output logic [NREQ-1:0] win_oh,
    output logic [PW-1:0]   win_idx,
    output logic            win_vld
);

    logic [PW-1:0] ptr;

    always_comb begin
        int j;
        win_oh  = '0;
        win_idx = '0;
        win_vld = 1'b0;
        j       = 0;
        for (int n = 0; n < NREQ; n++) begin
            j = (int'(ptr) + n) % NREQ;
            if (!win_vld && req[j]) begin
                win_vld    = 1'b1;
                win_oh[j]  = 1'b1;
                win_idx    = PW'(j);
            end
        end
    end

    // Winner drops to lowest priority for the next round.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr <= '0;
        end else if (adv && win_vld) begin
            ptr <= (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
        end
    end

endmodule

// File: rtl/sr_bank_ctrl.sv
// Arbitrates set/clear/toggle commands onto an SR bank and verifies the readback.
// Latency: grant + s/r pulse one cycle after sampling, done/err three cycles after sampling.
// Backpressure: requests are sampled only in IDLE; one command every three cycles.
module sr_bank_ctrl #(
    parameter int NREQ  = 4,
    parameter int NBITS = 8,
    parameter int IDXW  = $clog2(NBITS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [2*NREQ-1:0]    op,
    input  logic [IDXW*NREQ-1:0] idx,
    input  logic                 clr_all,
    output logic [NREQ-1:0]      gnt,
    output logic [NBITS-1:0]     s_vec,
    output logic [NBITS-1:0]     r_vec,
    input  logic [NBITS-1:0]     q_vec,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);
    import sr_bank_pkg::*;

    localparam int PW = $clog2(NREQ);
    localparam logic [NBITS-1:0] BIT0 = {{(NBITS-1){1'b0}}, 1'b1};

    state_t            state;
    logic              clr_q;
    op_t               op_q;
    logic [NBITS-1:0]  mask_q;
    logic              q_old_q;

    logic [NREQ-1:0]   win_oh;
    logic [PW-1:0]     win_idx;
    logic              win_vld;
    logic              adv;

    op_t               sel_op;
    logic [IDXW-1:0]   sel_idx;
    logic [NBITS-1:0]  sel_mask;
    logic              sel_q;
    logic              exp_bit;
    logic              chk_err;

    // clr_all takes the slot without consuming the requester's turn.
    assign adv = (state == ST_IDLE) && !clr_all;

    sr_rr_arb #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .adv     (adv),
        .win_oh  (win_oh),
        .win_idx (win_idx),
        .win_vld (win_vld)
    );

    // An out-of-range index shifts the bit off the end, leaving an empty mask.
    always_comb begin
        sel_op   = op[int'(win_idx) * 2 +: 2];
        sel_idx  = idx[int'(win_idx) * IDXW +: IDXW];
        sel_mask = BIT0 << sel_idx;
        sel_q    = |(q_vec & sel_mask);
    end

    always_comb begin
        exp_bit = (op_q == OP_SET) || ((op_q == OP_TGL) && !q_old_q);
        if (clr_q) begin
            chk_err = (q_vec != '0);
        end else if ((op_q == OP_NOP) || (mask_q == '0)) begin
            chk_err = 1'b1;
        end else begin
            chk_err = ((|(q_vec & mask_q)) != exp_bit);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            clr_q   <= 1'b0;
            op_q    <= OP_NOP;
            mask_q  <= '0;
            q_old_q <= 1'b0;
            gnt     <= '0;
            s_vec   <= '0;
            r_vec   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            gnt   <= '0;
            s_vec <= '0;
            r_vec <= '0;
            done  <= 1'b0;
            err   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (clr_all) begin
                        clr_q  <= 1'b1;
                        op_q   <= OP_CLR;
                        mask_q <= '1;
                        r_vec  <= '1;
                        busy   <= 1'b1;
                        state  <= ST_DRIVE;
                    end else if (win_vld) begin
                        clr_q   <= 1'b0;
                        op_q    <= sel_op;
                        mask_q  <= sel_mask;
                        q_old_q <= sel_q;
                        gnt     <= win_oh;
                        busy    <= 1'b1;
                        state   <= ST_DRIVE;
                        // s and r come from exclusive branches, so never both on a bit.
                        case (sel_op)
                            OP_SET: s_vec <= sel_mask;
                            OP_CLR: r_vec <= sel_mask;
                            OP_TGL: begin
                                if (sel_q) r_vec <= sel_mask;
                                else       s_vec <= sel_mask;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_DRIVE: begin
                    state <= ST_CHECK;
                end
                ST_CHECK: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    err   <= chk_err;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sr_bank_ctrl.sv
// Bench for sr_bank_ctrl: directed vector table, mid-command reset, then random commands vs a transaction model.
module tb_sr_bank_ctrl;

    localparam int NREQ  = 4;
    localparam int NBITS = 8;
    localparam int IDXW  = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  req = '0;
    logic [7:0]  op = '0;
    logic [15:0] idx = '0;
    logic        clr_all = 1'b0;
    logic [3:0]  gnt;
    logic [7:0]  s_vec, r_vec, q_vec;
    logic        busy, done, err;

    logic [7:0]  bank_q = '0;
    logic [7:0]  stuck = '0;

    int n_chk = 0;
    int n_fail = 0;

    int         m_ptr = 0;
    logic [7:0] m_bank = '0;

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [7:0]  op;
        logic [15:0] idx;
        logic        clr;
        logic [7:0]  stuck;
        logic [3:0]  gnt;
        logic [7:0]  s;
        logic [7:0]  r;
        logic        err;
    } vec_t;

    vec_t tbl [14];

    sr_bank_ctrl #(
        .NREQ  (NREQ),
        .NBITS (NBITS),
        .IDXW  (IDXW)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .op      (op),
        .idx     (idx),
        .clr_all (clr_all),
        .gnt     (gnt),
        .s_vec   (s_vec),
        .r_vec   (r_vec),
        .q_vec   (q_vec),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    always #5 clk = ~clk;

    // SR bank: bits can be held at 0 on readback to emulate a stuck cell.
    always @(posedge clk) bank_q <= (bank_q | s_vec) & ~r_vec;
    assign q_vec = bank_q & ~stuck;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("s_and_r_overlap", 32'(s_vec & r_vec), 32'd0);
        if (r_vec != 8'hFF)
            chk("single_pulse", 32'($countones(s_vec | r_vec) <= 1), 32'd1);
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic run_txn(input vec_t v, input string tag);
        if (v.rst) do_reset();
        @(negedge clk);
        stuck   = v.stuck;
        req     = v.req;
        op      = v.op;
        idx     = v.idx;
        clr_all = v.clr;
        @(posedge clk); #1;
        req     = '0;
        clr_all = 1'b0;
        chk({tag, ".drive.gnt"},  32'(gnt),   32'(v.gnt));
        chk({tag, ".drive.s"},    32'(s_vec), 32'(v.s));
        chk({tag, ".drive.r"},    32'(r_vec), 32'(v.r));
        chk({tag, ".drive.busy"}, 32'(busy),  32'd1);
        chk({tag, ".drive.done"}, 32'(done),  32'd0);
        @(posedge clk); #1;
        chk({tag, ".check.gnt"},  32'(gnt),   32'd0);
        chk({tag, ".check.sr"},   32'(s_vec | r_vec), 32'd0);
        chk({tag, ".check.busy"}, 32'(busy),  32'd1);
        chk({tag, ".check.done"}, 32'(done),  32'd0);
        @(posedge clk); #1;
        chk({tag, ".done"},      32'(done), 32'd1);
        chk({tag, ".err"},       32'(err),  32'(v.err));
        chk({tag, ".done.busy"}, 32'(busy), 32'd0);
    endtask

    // Transaction-level reference: picks the winner by rotating priority and
    // drives the target bit toward the value the opcode asks for.
    task automatic model(input logic [3:0] rq, input logic [7:0] o, input logic [15:0] ix,
                         input logic c, input logic [7:0] st, output vec_t v);
        int         k;
        logic [1:0] oi;
        logic [3:0] ii;
        logic [7:0] seen;
        logic       tgt;
        v = '{rst: 1'b0, req: rq, op: o, idx: ix, clr: c, stuck: st,
              gnt: 4'h0, s: 8'h00, r: 8'h00, err: 1'b0};
        if (c) begin
            v.r    = 8'hFF;
            m_bank = 8'h00;
            v.err  = ((m_bank & ~st) != 8'h00);
        end else begin
            k = -1;
            for (int n = 0; n < NREQ; n++)
                if (k < 0 && rq[(m_ptr + n) % NREQ]) k = (m_ptr + n) % NREQ;
            m_ptr = (k + 1) % NREQ;
            v.gnt[k] = 1'b1;
            oi = o[2*k +: 2];
            ii = ix[4*k +: 4];
            if (oi == 2'b00 || ii >= 4'd8) begin
                v.err = 1'b1;
            end else begin
                seen = m_bank & ~st;
                tgt  = (oi == 2'b01) ? 1'b1 : (oi == 2'b10) ? 1'b0 : !seen[ii[2:0]];
                if (tgt) v.s[ii[2:0]] = 1'b1;
                else     v.r[ii[2:0]] = 1'b1;
                m_bank[ii[2:0]] = tgt;
                seen  = m_bank & ~st;
                v.err = (seen[ii[2:0]] != tgt);
            end
        end
    endtask

    initial begin
        vec_t       v;
        logic [3:0] rq;
        logic [7:0] o, st;
        logic [15:0] ix;
        logic       c;

        //          rst   req      op     idx       clr   stuck  gnt      s      r      err
        tbl[0]  = '{1'b0, 4'b0001, 8'h01, 16'h0003, 1'b0, 8'h00, 4'b0001, 8'h08, 8'h00, 1'b0};
        tbl[1]  = '{1'b0, 4'b0010, 8'h0C, 16'h0030, 1'b0, 8'h00, 4'b0010, 8'h00, 8'h08, 1'b0};
        tbl[2]  = '{1'b1, 4'b1111, 8'h55, 16'h3210, 1'b0, 8'h00, 4'b0001, 8'h01, 8'h00, 1'b0};
        tbl[3]  = '{1'b0, 4'b1110, 8'h55, 16'h3210, 1'b0, 8'h00, 4'b0010, 8'h02, 8'h00, 1'b0};
        tbl[4]  = '{1'b0, 4'b1100, 8'h55, 16'h3210, 1'b0, 8'h00, 4'b0100, 8'h04, 8'h00, 1'b0};
        tbl[5]  = '{1'b0, 4'b1000, 8'h55, 16'h3210, 1'b0, 8'h00, 4'b1000, 8'h08, 8'h00, 1'b0};
        tbl[6]  = '{1'b0, 4'b0011, 8'h55, 16'h3210, 1'b0, 8'h00, 4'b0001, 8'h01, 8'h00, 1'b0};
        tbl[7]  = '{1'b0, 4'b0100, 8'h55, 16'h3210, 1'b1, 8'h00, 4'b0000, 8'h00, 8'hFF, 1'b0};
        tbl[8]  = '{1'b0, 4'b0100, 8'h55, 16'h3210, 1'b0, 8'h00, 4'b0100, 8'h04, 8'h00, 1'b0};
        tbl[9]  = '{1'b0, 4'b0001, 8'h54, 16'h3215, 1'b0, 8'h00, 4'b0001, 8'h00, 8'h00, 1'b1};
        tbl[10] = '{1'b0, 4'b0010, 8'h55, 16'h3295, 1'b0, 8'h00, 4'b0010, 8'h00, 8'h00, 1'b1};
        tbl[11] = '{1'b0, 4'b0100, 8'h55, 16'h3695, 1'b0, 8'h40, 4'b0100, 8'h40, 8'h00, 1'b1};
        tbl[12] = '{1'b0, 4'b1000, 8'h95, 16'h2695, 1'b0, 8'h00, 4'b1000, 8'h00, 8'h04, 1'b0};
        tbl[13] = '{1'b0, 4'b1000, 8'hD5, 16'h6695, 1'b0, 8'h00, 4'b1000, 8'h00, 8'h40, 1'b0};

        #1;
        chk("reset.gnt",  32'(gnt),   32'd0);
        chk("reset.s",    32'(s_vec), 32'd0);
        chk("reset.r",    32'(r_vec), 32'd0);
        chk("reset.busy", 32'(busy),  32'd0);
        chk("reset.done", 32'(done),  32'd0);
        chk("reset.err",  32'(err),   32'd0);
        do_reset();

        for (int i = 0; i < 14; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

        // Reset while the set pulse is on the bank lines: everything drops at once.
        @(negedge clk);
        req = 4'b0001; op = 8'h55; idx = 16'h3210; stuck = 8'h00;
        @(posedge clk); #1;
        req = '0;
        chk("midrst.gnt_before", 32'(gnt), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("midrst.gnt",  32'(gnt),   32'd0);
        chk("midrst.s",    32'(s_vec), 32'd0);
        chk("midrst.r",    32'(r_vec), 32'd0);
        chk("midrst.busy", 32'(busy),  32'd0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("midrst.no_done", 32'(done), 32'd0);
            chk("midrst.idle",    32'(busy), 32'd0);
        end

        m_ptr  = 0;
        m_bank = bank_q;
        for (int t = 0; t < 60; t++) begin
            rq = 4'($urandom_range(1, 15));
            o  = 8'($urandom);
            for (int k = 0; k < NREQ; k++) ix[4*k +: 4] = 4'($urandom_range(0, 9));
            c  = ($urandom_range(0, 7) == 0);
            st = ($urandom_range(0, 5) == 0) ? (8'h01 << $urandom_range(0, 7)) : 8'h00;
            model(rq, o, ix, c, st, v);
            run_txn(v, $sformatf("rnd%0d", t));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sr_bank_ctrl.md
# sr_bank_ctrl

Command controller and round-robin arbiter for a shared bank of SR flip-flops. Up to NREQ requesters issue set/clear/toggle commands against single bits of an NBITS-wide SR register bank; the controller grants one requester at a time, drives one-cycle `s`/`r` pulses into the bank, and reads back `q` to confirm the result. It guarantees the bank never sees `s = r = 1` on any bit.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- NBITS, 8, width of the SR bank
- IDXW, $clog2(NBITS), bit-index width

Ports:
- clk  input  1  single clock, all state on rising edge
- reset  input  1  asynchronous, active-low; one clock; asserted (0) clears all state immediately
- req  input  NREQ  per-requester request, held until granted
- op  input  2*NREQ  per-requester opcode: 00 nop, 01 set, 10 clear, 11 toggle
- idx  input  IDXW*NREQ  per-requester target bit index
- clr_all  input  1  global clear request, priority over req
- gnt  output  NREQ  one-hot grant, one-cycle pulse
- s_vec  output  NBITS  set pulses to bank
- r_vec  output  NBITS  reset pulses to bank
- q_vec  input  NBITS  bank state readback
- busy  output  1  command in flight (state != IDLE)
- done  output  1  one-cycle completion pulse
- err  output  1  valid with done: command failed

## Operation
- FSM states: IDLE, DRIVE, CHECK. Reset → IDLE.
- IDLE: if clr_all=1 → latch "clear all", no gnt, → DRIVE. Else if any req → arbiter picks winner k, latch op[k], idx[k], q_vec[idx[k]], → DRIVE. Else stay.
- DRIVE (1 cycle): gnt[k]=1 (not for clr_all). set: s_vec[idx]=1; clear: r_vec[idx]=1; toggle: latched q=1 → r_vec[idx]=1, else s_vec[idx]=1; clear-all: r_vec = all ones. nop or idx ≥ NBITS: no pulse. → CHECK.
- CHECK (1 cycle): s_vec=r_vec=0; compare q_vec against expected (set/toggle-to-1: bit=1; clear/toggle-to-0: bit=0; clear-all: q_vec==0). → IDLE, registering done=1 and err=mismatch (err=1 unconditionally for nop or out-of-range idx).
- Round-robin: after grant to k, priority order starts at k+1 mod NREQ. clr_all grants do not move the pointer. Reset pointer: requester 0 highest.
- Invariant: (s_vec & r_vec) == 0 every cycle; at most one bit of s_vec|r_vec set except clear-all.
- Requester drops req the cycle after seeing gnt; a req still high in the done cycle is re-arbitrated as a new command.

## Timing
- Reset values: gnt=0, s_vec=0, r_vec=0, busy=0, done=0, err=0, state IDLE, pointer 0. All outputs registered.
- Edge E0 samples req in IDLE; cycle after E0: gnt and s/r pulse high, busy=1. Bank samples s/r at E1. Cycle after E1: CHECK, busy=1. Cycle after E2: done/err high, busy=0, and a new grant may be sampled at that same E2 edge? No — new sampling occurs at E2 only if state is IDLE; it is not, so next sample is E3. Throughput: one command per 3 cycles; latency req→done = 3 cycles.
- clr_all and req in same IDLE cycle: clr_all wins; req waits, no gnt.
- Reset mid-command: outputs drop to 0 asynchronously, command lost, no done.
- Inputs sampled only in IDLE; changes during DRIVE/CHECK ignored.

## Structure
- Package sr_bank_pkg: opcode localparams (OP_NOP, OP_SET, OP_CLR, OP_TGL), FSM state encoding.
- Sub-module sr_rr_arb: parameterized NREQ round-robin arbiter (req vector, advance strobe, one-hot winner, pointer register with async active-low reset).
- Controller top: FSM, command latch, s/r decode, check compare.

## Test plan
- Reset then req[0]=1, op=01, idx=3 → gnt[0] one cycle, s_vec=8'h08 one cycle, done=1 err=0 three cycles after sample, q_vec[3]=1.
- req[1] toggle idx=3 with q_vec[3]=1 → r_vec=8'h08, done err=0, q_vec[3]=0.
- req=4'b1111 all set, distinct idx 0..3 → grants in order 0,1,2,3, each 3 cycles apart; then req=4'b0011 → grant 0 next (pointer wrapped after 3).
- clr_all=1 and req[2]=1 same cycle → r_vec=8'hFF, no gnt, done err=0, q_vec=0; req[2] granted next.
- op=00 or idx=9 (NBITS=8) → gnt pulse, s_vec=r_vec=0, done with err=1; bank model forced stuck → err=1.
- reset asserted during DRIVE → s_vec/r_vec/gnt 0 immediately, no done; check s_vec & r_vec == 0 throughout all scenarios.
